led_pattern_sequencer: RTL and testbench

LED_PATTERN_SEQUENCER -- requirements
Module: led_pattern_sequencer

---
 rtl/led_pattern_sequencer.sv | 135 +++++++++++++
 tb/tb_led_pattern_sequencer.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_sequencer.sv
// rtl/led_pattern_sequencer.sv - one-hot LED pattern stepper with up/down/ping-pong/hold modes
// Steps on a divided tick, or on a synchronized single-step press while paused.
module led_pattern_sequencer #(
  parameter int unsigned TICK_DIV = 32'd12_500_000,
  parameter int unsigned STATE_W  = 3
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [3:0] KEY,
  input  logic [9:0] SW,
  output logic [9:0] LEDR
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DOWN = 2'b01,
    MODE_PING = 2'b10,
    MODE_HOLD = 2'b11
  } mode_e;

  localparam logic [31:0]        TICK_LAST = 32'(TICK_DIV - 1);
  localparam logic [STATE_W-1:0] S_ZERO    = '0;
  localparam logic [STATE_W-1:0] S_ONE     = STATE_W'(1);
  localparam logic [STATE_W-1:0] S_MAX     = '1;

  logic [1:0]         key_meta_q, key_meta_d;
  logic [1:0]         key_sync_q, key_sync_d;
  logic [1:0]         key_prev_q, key_prev_d;
  logic [2:0]         sw_meta_q,  sw_meta_d;
  logic [2:0]         sw_sync_q,  sw_sync_d;
  logic [31:0]        count_q,    count_d;
  logic [STATE_W-1:0] s_q,        s_d;
  logic               dir_q,      dir_d;

  logic [1:0] press;
  logic       tick;
  logic       paused;
  logic       advance;
  logic       restart;
  mode_e      mode;
  logic [7:0] onehot;
  logic       unused_inputs;

  assign unused_inputs = &{1'b0, KEY[3:2], SW[9:3]};

  always_comb begin
    key_meta_d = KEY[1:0];
    key_sync_d = key_meta_q;
    key_prev_d = key_sync_q;
    sw_meta_d  = SW[2:0];
    sw_sync_d  = sw_meta_q;
  end

  // Keys are active-low, so a press is a synchronized 1 -> 0 transition.
  assign press   = key_prev_q & ~key_sync_q;
  assign restart = press[1];
  assign paused  = sw_sync_q[2];
  assign mode    = mode_e'(sw_sync_q[1:0]);

  assign tick    = (count_q == TICK_LAST);
  assign advance = (tick & ~paused) | (press[0] & paused);

  always_comb begin
    count_d = tick ? 32'd0 : count_q + 32'd1;
  end

  always_comb begin
    s_d   = s_q;
    dir_d = dir_q;
    if (restart) begin
      s_d   = S_ZERO;
      dir_d = 1'b0;
    end else if (advance) begin
      case (mode)
        MODE_UP: begin
          s_d   = s_q + S_ONE;
          dir_d = 1'b0;
        end
        MODE_DOWN: begin
          s_d   = s_q - S_ONE;
          dir_d = 1'b1;
        end
        MODE_PING: begin
          // Bounce at the ends: turn around and take the step back in the same cycle.
          if (!dir_q) begin
            if (s_q == S_MAX) begin
              s_d   = S_MAX - S_ONE;
              dir_d = 1'b1;
            end else begin
              s_d = s_q + S_ONE;
            end
          end else begin
            if (s_q == S_ZERO) begin
              s_d   = S_ONE;
              dir_d = 1'b0;
            end else begin
              s_d = s_q - S_ONE;
            end
          end
        end
        default: begin
          s_d   = s_q;
          dir_d = dir_q;
        end
      endcase
    end
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      key_meta_q <= 2'b11;
      key_sync_q <= 2'b11;
      key_prev_q <= 2'b11;
      sw_meta_q  <= 3'b000;
      sw_sync_q  <= 3'b000;
      count_q    <= 32'd0;
      s_q        <= S_ZERO;
      dir_q      <= 1'b0;
    end else begin
      key_meta_q <= key_meta_d;
      key_sync_q <= key_sync_d;
      key_prev_q <= key_prev_d;
      sw_meta_q  <= sw_meta_d;
      sw_sync_q  <= sw_sync_d;
      count_q    <= count_d;
      s_q        <= s_d;
      dir_q      <= dir_d;
    end
  end

  // Upper one-hot bits stay zero for narrow STATE_W since s never exceeds its max.
  assign onehot = 8'd1 << s_q;
  assign LEDR   = {dir_q, sw_sync_q[2], onehot};

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb/tb_led_pattern_sequencer.sv - directed bench for led_pattern_sequencer (TICK_DIV=4, STATE_W=3)
module tb_led_pattern_sequencer;

  logic       CLOCK_50;
  logic       RESET_N;
  logic [3:0] KEY;
  logic [9:0] SW;
  logic [9:0] LEDR;

  int vectors = 0;
  int errors  = 0;

  led_pattern_sequencer #(
    .TICK_DIV(4),
    .STATE_W (3)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET_N (RESET_N),
    .KEY     (KEY),
    .SW      (SW),
    .LEDR    (LEDR)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  function automatic logic [7:0] oh(input int s);
    logic [7:0] one;
    one = 8'd1;
    return one << s;
  endfunction

  task automatic test_reset();
    RESET_N = 1'b0;
    KEY     = 4'hF;
    SW      = 10'h000;
    repeat (2) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h001) begin
      errors++;
      $display("FAIL reset_state: LEDR=%h expected %h", LEDR, 10'h001);
    end
    RESET_N = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(negedge CLOCK_50);
      vectors++;
      if (LEDR !== 10'h001) begin
        errors++;
        $display("FAIL no_early_tick c=%0d: LEDR=%h expected %h", c, LEDR, 10'h001);
      end
    end
    @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h002) begin
      errors++;
      $display("FAIL first_advance: LEDR=%h expected %h", LEDR, 10'h002);
    end
  endtask

  // Starts aligned just after an advance, s=1; a step press while unpaused must be ignored.
  task automatic test_up();
    logic [9:0] exp_hold, exp_step;
    for (int i = 0; i < 8; i++) begin
      exp_hold = {2'b00, oh((1 + i) % 8)};
      exp_step = {2'b00, oh((2 + i) % 8)};
      if (i == 1) KEY[0] = 1'b0;
      @(negedge CLOCK_50);
      KEY[0] = 1'b1;
      repeat (2) @(negedge CLOCK_50);
      vectors++;
      if (LEDR !== exp_hold) begin
        errors++;
        $display("FAIL up_hold i=%0d: LEDR=%h expected %h", i, LEDR, exp_hold);
      end
      @(negedge CLOCK_50);
      vectors++;
      if (LEDR !== exp_step) begin
        errors++;
        $display("FAIL up_step i=%0d: LEDR=%h expected %h", i, LEDR, exp_step);
      end
    end
  endtask

  task automatic test_pingpong();
    int         exp_s [16] = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2, 3};
    bit         exp_d [16] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
    logic [9:0] exp;
    SW[1:0] = 2'b10;
    for (int i = 0; i < 16; i++) begin
      repeat (4) @(negedge CLOCK_50);
      exp = {exp_d[i], 1'b0, oh(exp_s[i])};
      vectors++;
      if (LEDR !== exp) begin
        errors++;
        $display("FAIL pingpong i=%0d: LEDR=%h expected %h", i, LEDR, exp);
      end
    end
  endtask

  // Starts aligned at s=3 in ping-pong going up; ends 40 cycles later, still tick-aligned.
  task automatic test_pause_step();
    SW[2] = 1'b1;
    repeat (12) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h108) begin
      errors++;
      $display("FAIL pause_freeze: LEDR=%h expected %h", LEDR, 10'h108);
    end
    KEY[0] = 1'b0;
    @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h108) begin
      errors++;
      $display("FAIL step_early: LEDR=%h expected %h", LEDR, 10'h108);
    end
    @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h110) begin
      errors++;
      $display("FAIL step_third_edge: LEDR=%h expected %h", LEDR, 10'h110);
    end
    KEY[0] = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h120) begin
      errors++;
      $display("FAIL hold_key_first: LEDR=%h expected %h", LEDR, 10'h120);
    end
    repeat (17) @(negedge CLOCK_50);
    KEY[0] = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h120) begin
      errors++;
      $display("FAIL hold_key_single: LEDR=%h expected %h", LEDR, 10'h120);
    end
  endtask

  // Unpause so the next tick would move 5->6; the restart press lands on that same edge.
  task automatic test_restart_priority();
    SW[2] = 1'b0;
    @(negedge CLOCK_50);
    KEY[1] = 1'b0;
    @(negedge CLOCK_50);
    KEY[1] = 1'b1;
    @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h020) begin
      errors++;
      $display("FAIL restart_pre: LEDR=%h expected %h", LEDR, 10'h020);
    end
    @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h001) begin
      errors++;
      $display("FAIL restart_priority: LEDR=%h expected %h", LEDR, 10'h001);
    end
  endtask

  task automatic test_down_hold();
    SW[1:0] = 2'b01;
    repeat (4) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h280) begin
      errors++;
      $display("FAIL down_wrap: LEDR=%h expected %h", LEDR, 10'h280);
    end
    SW[1:0] = 2'b11;
    for (int k = 0; k < 10; k++) begin
      repeat (4) @(negedge CLOCK_50);
      vectors++;
      if (LEDR !== 10'h280) begin
        errors++;
        $display("FAIL hold_freeze k=%0d: LEDR=%h expected %h", k, LEDR, 10'h280);
      end
    end
  endtask

  task automatic test_async_reset();
    SW[1:0] = 2'b01;
    repeat (4) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h240) begin
      errors++;
      $display("FAIL down_to_6: LEDR=%h expected %h", LEDR, 10'h240);
    end
    #2;
    RESET_N = 1'b0;
    #1;
    vectors++;
    if (LEDR !== 10'h001) begin
      errors++;
      $display("FAIL async_clear: LEDR=%h expected %h", LEDR, 10'h001);
    end
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h001) begin
      errors++;
      $display("FAIL post_reset_early: LEDR=%h expected %h", LEDR, 10'h001);
    end
    @(negedge CLOCK_50);
    vectors++;
    if (LEDR !== 10'h280) begin
      errors++;
      $display("FAIL post_reset_advance: LEDR=%h expected %h", LEDR, 10'h280);
    end
  endtask

  initial begin
    test_reset();
    test_up();
    test_pingpong();
    test_pause_step();
    test_restart_priority();
    test_down_hold();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
